// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter and its bus watchdog.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_ERR  = 2'd3
    } arb_state_e;

    localparam int unsigned M0 = 0;
    localparam int unsigned M1 = 1;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    // A limit of 0 still needs a 1-bit counter so the declaration stays legal.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Counts consecutive enabled cycles and pulses o_expire on the cycle the count hits TIMEOUT_CYCLES.
module wb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned   CW   = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    // The enabled cycle that finds the counter at LAST is the TIMEOUT_CYCLES-th one.
    assign w_at_last = (TIMEOUT_CYCLES != 0) && (r_count == LAST);
    assign o_expire  = i_enable && w_at_last;

    always_ff @(posedge i_clk) begin
        if (i_rst || !i_enable || w_at_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter: registered round-robin grant, cyc-locked ownership,
// and a watchdog that error-terminates a strobe the slave never acknowledges.
module wb_arbiter_2m
    import wb_arb_pkg::*;
#(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic [DW-1:0]   m0_dat_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [DW-1:0]   m1_dat_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,

    output logic [1:0]      grant_o,
    output logic            timeout_o
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_GNT0 = ST_GNT0;
    localparam logic [1:0] S_GNT1 = ST_GNT1;
    localparam logic [1:0] S_ERR  = ST_ERR;

    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic       r_last_grant;
    logic       w_grant_next;
    logic       w_gnt;
    logic       w_own_cyc;
    logic       w_wd_enable;
    logic       w_wd_expire;

    // Outside IDLE the current owner is always the last master granted.
    assign w_gnt     = (r_state == S_GNT0) || (r_state == S_GNT1);
    assign w_own_cyc = (r_last_grant == 1'(M1)) ? m1_cyc_i : m0_cyc_i;

    assign grant_o   = (r_state == S_IDLE) ? 2'b00 :
                       ((r_last_grant == 1'(M1)) ? 2'b10 : 2'b01);
    assign timeout_o = (r_state == S_ERR);

    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (w_gnt) begin
            if (r_last_grant == 1'(M1)) begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end else begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
        end
    end

    always_comb begin
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_dat_o = '0;
        if (r_state == S_GNT0) begin
            m0_ack_o = s_ack_i & m0_stb_i;
            m0_dat_o = s_dat_i;
        end
        if (r_state == S_GNT1) begin
            m1_ack_o = s_ack_i & m1_stb_i;
            m1_dat_o = s_dat_i;
        end
        if (r_state == S_ERR) begin
            m0_err_o = (r_last_grant == 1'(M0));
            m1_err_o = (r_last_grant == 1'(M1));
        end
    end

    // An ack arriving on the limit cycle drops enable, so it always wins over the timeout.
    assign w_wd_enable = w_gnt & s_stb_o & ~s_ack_i;

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk    (wb_clk_i),
        .i_rst    (wb_rst_i),
        .i_enable (w_wd_enable),
        .o_expire (w_wd_expire)
    );

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_last_grant;
        case (r_state)
            S_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || (r_last_grant == 1'(M1)))) begin
                    w_state_next = S_GNT0;
                    w_grant_next = 1'(M0);
                end else if (m1_cyc_i) begin
                    w_state_next = S_GNT1;
                    w_grant_next = 1'(M1);
                end
            end
            S_GNT0, S_GNT1: begin
                if (!w_own_cyc) begin
                    w_state_next = S_IDLE;
                end else if (w_wd_expire) begin
                    w_state_next = S_ERR;
                end
            end
            S_ERR: begin
                if (w_own_cyc) begin
                    w_state_next = (r_last_grant == 1'(M1)) ? S_GNT1 : S_GNT0;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'(M1);
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_grant_next;
        end
    end

endmodule
